// File: rtl/seq_pkg.sv
// Shared types and 7-segment helpers for the serial pattern transmitter and
// its partner sequence detector display.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width: enough for 0..9 (PAT_W is at most 9).
  localparam int BCNT_W = 4;

  // Active-low segment codes, bit 6 = a ... bit 0 = g.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decimal digit to active-low segment code; out-of-range values blank.
  function automatic logic [6:0] seg7(input logic [3:0] val);
    logic [6:0] code;
    case (val)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Control and serial-data bundle of the pattern transmitter.
//
// Handshake: start is a request that is accepted on a clk edge only while the
// transmitter is in IDLE or DONE (busy=0 or done=1); a start seen while busy
// is dropped, not queued. pattern and repeat_en are sampled on that same edge
// (and repeat_en/pattern again at each frame's last bit). bit_vld is the valid
// qualifier for x_out: x_out carries a pattern bit exactly when bit_vld=1, and
// the receiver has no back-pressure. done marks the cycle after a frame ends.
interface serial_pattern_tx_if #(
  parameter int PAT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic             repeat_en;
  logic             x_out;
  logic             bit_vld;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_en,
    input  x_out, bit_vld, busy, done
  );

  modport slave (
    input  start, pattern, repeat_en,
    output x_out, bit_vld, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx_tick_gen.sv
// Bit-rate prescaler: counts 0..DIV-1 while enabled and flags the final count.
module tick_gen #(
  parameter int DIV   = 4,
  parameter int CNT_W = $clog2(DIV + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Prescaler counter: cleared at frame start, wraps after the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: latches a PAT_W-bit pattern and shifts it out
// MSB-first on x_out, each bit held DIV cycles, with a 7-seg progress display.
module serial_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int DIV   = 20000000,
  parameter int CNT_W = $clog2(DIV + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_pattern_tx_if.slave   bus,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 d,
  output logic                 e,
  output logic                 f,
  output logic                 g,
  output state_t               state_dbg
);

  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(PAT_W - 1);

  state_t             state, state_nxt;
  logic [PAT_W-1:0]   shreg, shreg_nxt, shreg_shl;
  logic [BCNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic               x_out_q, x_out_nxt;
  logic               bit_vld_q, bit_vld_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic [6:0]         seg_q, seg_nxt;
  logic               start_acc;
  logic               tick;

  assign shreg_shl = shreg << 1;

  tick_gen #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == SEND),
    .clr   (start_acc),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and next-datapath decode; every output is registered from here.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    x_out_nxt   = x_out_q;
    bit_vld_nxt = bit_vld_q;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
    start_acc   = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          start_acc   = 1'b1;
          state_nxt   = SEND;
          shreg_nxt   = bus.pattern;
          bit_cnt_nxt = '0;
          x_out_nxt   = bus.pattern[PAT_W-1];
          bit_vld_nxt = 1'b1;
          busy_nxt    = 1'b1;
        end else begin
          state_nxt   = IDLE;
          x_out_nxt   = 1'b0;
          bit_vld_nxt = 1'b0;
          busy_nxt    = 1'b0;
        end
      end

      SEND: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            if (bus.repeat_en) begin
              // Reload for the next frame with no idle gap.
              shreg_nxt   = bus.pattern;
              bit_cnt_nxt = '0;
              x_out_nxt   = bus.pattern[PAT_W-1];
            end else begin
              // Counter lands on PAT_W so the display shows the full frame.
              state_nxt   = DONE;
              bit_cnt_nxt = bit_cnt + 1'b1;
              x_out_nxt   = 1'b0;
              bit_vld_nxt = 1'b0;
              busy_nxt    = 1'b0;
              done_nxt    = 1'b1;
            end
          end else begin
            shreg_nxt   = shreg_shl;
            bit_cnt_nxt = bit_cnt + 1'b1;
            x_out_nxt   = shreg_shl[PAT_W-1];
          end
        end
      end

      default: begin
        state_nxt   = IDLE;
        x_out_nxt   = 1'b0;
        bit_vld_nxt = 1'b0;
        busy_nxt    = 1'b0;
      end
    endcase

    seg_nxt = seg7(bit_cnt_nxt);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      x_out_q   <= 1'b0;
      bit_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      seg_q     <= SEG_0;
    end else begin
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      x_out_q   <= x_out_nxt;
      bit_vld_q <= bit_vld_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      seg_q     <= seg_nxt;
    end
  end

  assign bus.x_out   = x_out_q;
  assign bus.bit_vld = bit_vld_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign {a, b, c, d, e, f, g} = seg_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: one DIV=4 instance for the frame scenarios and
// one DIV=1 instance for the back-to-back case.
module tb_serial_pattern_tx;
  import seq_pkg::*;

  localparam int PAT_W = 4;
  localparam int W     = 11;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_pattern_tx_if #(.PAT_W(PAT_W)) bus4 ();
  serial_pattern_tx_if #(.PAT_W(PAT_W)) bus1 ();

  logic a4, b4, c4, d4, e4, f4, g4;
  logic a1, b1, c1, d1, e1, f1, g1;
  state_t st4, st1;

  serial_pattern_tx #(.PAT_W(PAT_W), .DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4),
    .a(a4), .b(b4), .c(c4), .d(d4), .e(e4), .f(f4), .g(g4),
    .state_dbg(st4)
  );

  serial_pattern_tx #(.PAT_W(PAT_W), .DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
    .state_dbg(st1)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {x_out, bit_vld, busy, done, seg[6:0]}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v, got_v;
  int vectors = 0;
  int errors  = 0;

  localparam logic [W-1:0] RESET_V = {4'b0000, 7'b0000001};

  function automatic logic [6:0] seg_ref(input int n);
    case (n)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [W-1:0] got4();
    return {bus4.x_out, bus4.bit_vld, bus4.busy, bus4.done, a4, b4, c4, d4, e4, f4, g4};
  endfunction

  function automatic logic [W-1:0] got1();
    return {bus1.x_out, bus1.bit_vld, bus1.busy, bus1.done, a1, b1, c1, d1, e1, f1, g1};
  endfunction

  task automatic push_frame(input logic [PAT_W-1:0] p, input int div);
    for (int bi = 0; bi < PAT_W; bi++)
      for (int k = 0; k < div; k++)
        exp_q.push_back({p[PAT_W-1-bi], 1'b1, 1'b1, 1'b0, seg_ref(bi)});
  endtask

  task automatic push_done();
    exp_q.push_back({4'b0001, seg_ref(PAT_W)});
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({4'b0000, seg_ref(PAT_W)});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus4.start = 1'b0; bus4.pattern = '0; bus4.repeat_en = 1'b0;
    bus1.start = 1'b0; bus1.pattern = '0; bus1.repeat_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (got4() !== RESET_V) begin
      errors++; $display("FAIL reset_hold4: got %b expected %b", got4(), RESET_V);
    end
    vectors++;
    if (got1() !== RESET_V) begin
      errors++; $display("FAIL reset_hold1: got %b expected %b", got1(), RESET_V);
    end
    vectors++;
    if (st4 !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", st4, IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus4.pattern = 4'b1111; bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (got4() !== RESET_V) begin
      errors++; $display("FAIL reset_async: got %b expected %b", got4(), RESET_V);
    end
    @(negedge clk);
    vectors++;
    if (got4() !== RESET_V || st4 !== IDLE) begin
      errors++; $display("FAIL reset_nodone: got %b st %0d expected %b st 0", got4(), st4, RESET_V);
    end
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_single_frame();
    @(negedge clk);
    bus4.pattern = 4'b1001; bus4.repeat_en = 1'b0; bus4.start = 1'b1;
    push_frame(4'b1001, 4); push_done(); push_idle(2);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      bus4.start = 1'b0;
      exp_v = exp_q.pop_front();
      got_v = got4();
      vectors++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL single_frame: got %b expected %b", got_v, exp_v);
      end
      if (exp_v[7]) begin
        vectors++;
        if (st4 !== DONE) begin
          errors++; $display("FAIL single_done_state: got %0d expected %0d", st4, DONE);
        end
      end
    end
  endtask

  task automatic test_repeat();
    int i;
    @(negedge clk);
    bus4.pattern = 4'b1001; bus4.repeat_en = 1'b1; bus4.start = 1'b1;
    push_frame(4'b1001, 4); push_frame(4'b0110, 4); push_done(); push_idle(1);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      if (i == 0)  bus4.start = 1'b0;
      if (i == 5)  bus4.pattern = 4'b0110;
      if (i == 20) bus4.repeat_en = 1'b0;
      exp_v = exp_q.pop_front();
      got_v = got4();
      vectors++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL repeat_frames cyc %0d: got %b expected %b", i, got_v, exp_v);
      end
      i++;
    end
  endtask

  task automatic test_busy_start();
    int i;
    @(negedge clk);
    bus4.pattern = 4'b1010; bus4.repeat_en = 1'b0; bus4.start = 1'b1;
    push_frame(4'b1010, 4); push_done(); push_idle(2);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      if (i == 0)  bus4.start = 1'b0;
      if (i == 6)  begin bus4.start = 1'b1; bus4.pattern = 4'b1111; end
      if (i == 7)  bus4.start = 1'b0;
      if (i == 15) bus4.start = 1'b1;
      if (i == 16) bus4.start = 1'b0;
      exp_v = exp_q.pop_front();
      got_v = got4();
      vectors++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL busy_start cyc %0d: got %b expected %b", i, got_v, exp_v);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    bus4.pattern = 4'b1101; bus4.repeat_en = 1'b0; bus4.start = 1'b1;
    push_frame(4'b1101, 4);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus4.start = 1'b0;
      exp_v = exp_q.pop_front();
      got_v = got4();
      vectors++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL pre_reset cyc %0d: got %b expected %b", i, got_v, exp_v);
      end
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (got4() !== RESET_V) begin
      errors++; $display("FAIL midframe_reset: got %b expected %b", got4(), RESET_V);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (got4() !== RESET_V) begin
        errors++; $display("FAIL midframe_nodone %0d: got %b expected %b", k, got4(), RESET_V);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus4.start = 1'b1;
    push_frame(4'b1101, 4); push_done(); push_idle(1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      bus4.start = 1'b0;
      exp_v = exp_q.pop_front();
      got_v = got4();
      vectors++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL post_reset_frame: got %b expected %b", got_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int i;
    @(negedge clk);
    bus1.pattern = 4'b1011; bus1.repeat_en = 1'b0; bus1.start = 1'b1;
    push_frame(4'b1011, 1); push_done(); push_frame(4'b1011, 1); push_done(); push_idle(2);
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      if (i == 6) bus1.start = 1'b0;
      exp_v = exp_q.pop_front();
      got_v = got1();
      vectors++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL back_to_back cyc %0d: got %b expected %b", i, got_v, exp_v);
      end
      i++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_repeat();
    test_busy_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
